// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the ring/Johnson counter family.
// Helpers work on a 32-bit word; callers pass the live width.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

    localparam int MAX_W = 32;

    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t width_mask(input int width);
        word_t m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic word_t seed(input logic mode);
        return (mode == MODE_RING) ? word_t'(1) : '0;
    endfunction

    // Ring: exactly one hot bit. Johnson: at most one adjacent-bit transition.
    function automatic logic is_legal(input word_t q, input logic mode, input int width);
        int ones;
        int edges;
        ones  = 0;
        edges = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width && q[i]) ones++;
        end
        for (int i = 0; i < MAX_W - 1; i++) begin
            if (i < width - 1 && q[i] != q[i+1]) edges++;
        end
        return (mode == MODE_RING) ? (ones == 1) : (edges <= 1);
    endfunction

    function automatic word_t step(input word_t q, input logic mode, input logic dir,
                                   input int width);
        word_t r;
        logic  top;
        logic  bot;
        top = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == width - 1) top = q[i];
        end
        bot = q[0];
        if (mode == MODE_JOHNSON) begin
            top = ~top;
            bot = ~bot;
        end
        if (dir == DIR_DOWN) begin
            r = q >> 1;
            for (int i = 0; i < MAX_W; i++) begin
                if (i == width - 1) r[i] = bot;
            end
        end else begin
            r = {q[MAX_W-2:0], top};
        end
        return r & width_mask(width);
    endfunction

endpackage

// File: rtl/ring_pos_decode.sv
// Decodes counter state to a sequence index; reports 0 for illegal states.
module ring_pos_decode
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int POS_W = $clog2(2*WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic [POS_W-1:0] pos
);

    int ones;

    always_comb begin
        ones = $countones(q);
        pos  = '0;
        if (is_legal(word_t'(q), mode, WIDTH)) begin
            if (mode == MODE_RING) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (q[i]) pos = POS_W'(i);
                end
            end else if (!q[WIDTH-1]) begin
                pos = POS_W'(ones);
            end else begin
                pos = POS_W'(2*WIDTH - ones);
            end
        end
    end

endmodule

// File: rtl/ring_counter_multi.sv
// WIDTH-bit ring / Johnson sequencer with direction, enable, load,
// illegal-state self-correction, wrap pulse and decoded position.
module ring_counter_multi
    import ring_counter_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int POS_W = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err,
    output logic [POS_W-1:0] pos
);

    logic             mode_q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_stepped;
    logic             q_legal;
    logic             mode_next;
    logic             wrap_next;
    logic             err_next;

    // Priority: load, mode change reseed, illegal correction, step, hold.
    always_comb begin
        q_legal   = is_legal(word_t'(q), mode_q, WIDTH);
        q_stepped = WIDTH'(step(word_t'(q), mode_q, dir, WIDTH));
        q_next    = q;
        mode_next = mode_q;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (load) begin
            q_next = load_val;
        end else if (mode != mode_q) begin
            q_next    = WIDTH'(seed(mode));
            mode_next = mode;
        end else if (!q_legal) begin
            q_next   = WIDTH'(seed(mode_q));
            err_next = 1'b1;
        end else if (en) begin
            q_next    = q_stepped;
            wrap_next = (q_stepped == WIDTH'(seed(mode_q)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q      <= WIDTH'(1);
            mode_q <= MODE_RING;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            q      <= q_next;
            mode_q <= mode_next;
            wrap   <= wrap_next;
            err    <= err_next;
        end
    end

    ring_pos_decode #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_pos_decode (
        .q    (q),
        .mode (mode_q),
        .pos  (pos)
    );

endmodule

// File: doc/ring_counter_multi.md
Name: ring_counter_multi

Overview:
- Parametrised successor to the fixed 4-bit ring counter: a WIDTH-bit rotating counter with selectable ring (one-hot) or Johnson (twisted-ring) mode.
- Adds direction control, count enable, synchronous parallel load, illegal-state self-correction, a wrap pulse and a decoded position index.
- Used as a sequencer or phase generator for scan/strobe/timing logic; a single instance per sequence, fully synchronous to clk.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- POS_W, $clog2(2*WIDTH), width of the pos output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  step enable; 1 = advance one state per clock.
- dir  input  1  0 = up (rotate toward MSB), 1 = down (rotate toward LSB).
- mode  input  1  0 = ring (one-hot), 1 = Johnson.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value written to q on load.
- q  output  WIDTH  counter state, registered.
- wrap  output  1  registered; 1 for exactly the cycle in which q returns to the seed as the result of a step.
- err  output  1  registered; 1 for one cycle after the counter corrects an illegal state.
- pos  output  POS_W  combinational state index decoded from q and mode_q.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: q = {WIDTH-1 zeros, 1} (ring seed); internal mode_q = 0; wrap = 0; err = 0. All apply immediately on reset_n low, with no clock required.
- Seeds: ring seed = ...0001; Johnson seed = all zeros.
- Legality:
  - Ring: legal iff popcount(q) == 1.
  - Johnson: legal iff the number of positions i in 0..WIDTH-2 with q[i] != q[i+1] is at most 1.
  - Legality is evaluated against mode_q.
- Per-edge priority (highest first):
  1. load: q <= load_val, accepted verbatim even if illegal; wrap = 0, err = 0.
  2. mode != mode_q: q <= seed of the new mode; mode_q <= mode; wrap = 0, err = 0.
  3. q illegal: q <= seed; err <= 1; wrap = 0. Correction happens regardless of en.
  4. en = 1: step as below; wrap <= (next_q == seed); err <= 0.
  5. Otherwise: hold q; wrap = 0, err = 0.
- Step rules:
  - Ring up: {q[W-2:0], q[W-1]}.
  - Ring down: {q[0], q[W-1:1]}.
  - Johnson up: {q[W-2:0], ~q[W-1]}.
  - Johnson down: {~q[0], q[W-1:1]}.
- Sequence period: ring = WIDTH states; Johnson = 2*WIDTH states.
- wrap:
  - Asserted only by a step (branch 4).
  - Loading the seed, mode-change reseeding and illegal-state correction never assert wrap.
  - en held low keeps wrap low even while q == seed.
- pos (combinational; 0 while q is illegal):
  - Ring: index of the hot bit.
  - Johnson: popcount(q) if q[W-1] == 0, else 2*WIDTH - popcount(q).
- Latency: q, wrap and err all change one clock after the inputs are sampled; pos follows q in the same cycle.
- Direction may change on any cycle; the step uses dir as sampled on that edge. No direction-change penalty.
- Reset asserted mid-sequence or mid-load discards any pending operation.

Decomposition:
- Shared package ring_counter_pkg holds:
  - MODE_RING = 1'b0, MODE_JOHNSON = 1'b1;
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1;
  - functions seed(mode), is_legal(q, mode), step(q, mode, dir).
- One sub-module: ring_pos_decode, the combinational q/mode_q -> pos decoder with legality gating. Reused by display and monitor logic.

Test Plan:
- WIDTH=4, mode=0, dir=0, en=1 after reset: q 0001 -> 0010 -> 0100 -> 1000 -> 0001; wrap=1 only with the final 0001; pos 0,1,2,3,0.
- Ring, dir=1 from reset: q 0001 -> 1000 -> 0100; toggle dir to 0 mid-sequence -> 1000 next. No glitch on wrap.
- mode set to 1 from reset, en=1:
  - First edge: q=0000, wrap=0.
  - Then 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 with wrap=1 on 0000.
  - pos 1..7, 0.
- Ring, en=0, load=1 with load_val=0101: q=0101, err=0. Next edge: q=0001, err=1 for one cycle, then err=0.
- Counting in ring mode with q=0100: drive reset_n low between edges -> q=0001, wrap=0, err=0 immediately, with no clock edge.
- WIDTH=5, Johnson, dir=1 from 00000: q 10000 (pos 9) -> 11000 (pos 8). After 10 steps q=00000 with wrap=1.
